// File: rtl/ps2_key_scanner.sv
// PS/2 keyboard front end: synchronises and filters the raw PS/2 lines,
// receives device-to-host frames, decodes E0/F0 prefixes, tracks held keys
// for a configurable key set and queues decoded key events in a FWFT FIFO.
//
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   ps2_clk_i, ps2_data_i raw asynchronous PS/2 lines
//   evt_valid_o/ready_i   event queue handshake (pop on valid & ready)
//   evt_code_o/ext_o/break_o/repeat_o  head event fields
//   fifo_level_o          number of queued events
//   key_down_o            held state of tracked keys
//   rx_byte_o/valid_o     last good byte, one-cycle pulse per good byte
//   parity_err_o, frame_err_o, overflow_o, bat_ok_o  one-cycle status pulses
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, delivering the byte
module ps2_key_scanner #(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned NUM_KEYS    = 4,
  parameter logic [NUM_KEYS*9-1:0] KEYMAP = {9'h172, 9'h175, 9'h01B, 9'h01D}
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            ps2_clk_i,
  input  logic                            ps2_data_i,
  output logic                            evt_valid_o,
  input  logic                            evt_ready_i,
  output logic [7:0]                      evt_code_o,
  output logic                            evt_ext_o,
  output logic                            evt_break_o,
  output logic                            evt_repeat_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
  output logic [NUM_KEYS-1:0]             key_down_o,
  output logic [7:0]                      rx_byte_o,
  output logic                            rx_byte_valid_o,
  output logic                            parity_err_o,
  output logic                            frame_err_o,
  output logic                            overflow_o,
  output logic                            bat_ok_o
);

  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Input conditioning; everything presets high so reset release looks like an idle bus.
  logic [1:0]            clk_sync_q, data_sync_q;
  logic [FILTER_LEN-1:0] clk_hist_q, data_hist_q;
  logic                  clk_filt_q, data_filt_q, clk_filt_prev_q;
  logic                  fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q      <= '1;
      data_sync_q     <= '1;
      clk_hist_q      <= '1;
      data_hist_q     <= '1;
      clk_filt_q      <= 1'b1;
      data_filt_q     <= 1'b1;
      clk_filt_prev_q <= 1'b1;
    end else begin
      clk_sync_q      <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q     <= {data_sync_q[0], ps2_data_i};
      clk_hist_q      <= {clk_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
      data_hist_q     <= {data_hist_q[FILTER_LEN-2:0], data_sync_q[1]};
      if (&clk_hist_q)       clk_filt_q <= 1'b1;
      else if (~|clk_hist_q) clk_filt_q <= 1'b0;
      if (&data_hist_q)       data_filt_q <= 1'b1;
      else if (~|data_hist_q) data_filt_q <= 1'b0;
      clk_filt_prev_q <= clk_filt_q;
    end
  end

  assign fall = clk_filt_prev_q & ~clk_filt_q;

  // Receive FSM
  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q, rx_byte_q;
  logic          par_q, rx_valid_q, parity_err_q, frame_err_q, bat_ok_q;
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= TMO_LOAD;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      bat_ok_q     <= 1'b0;
    end else begin
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      bat_ok_q     <= 1'b0;
      if (fall) begin
        tmo_q <= TMO_LOAD;
        case (state_q)
          IDLE: begin
            if (!data_filt_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {data_filt_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= data_filt_q;
            state_q <= STOP;
          end
          default: begin
            state_q <= IDLE;
            if (!data_filt_q) begin
              frame_err_q <= 1'b1;
            end else if (^{shift_q, par_q}) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
              bat_ok_q   <= (shift_q == 8'hAA);
            end else begin
              parity_err_q <= 1'b1;
            end
          end
        endcase
      end else if (state_q != IDLE) begin
        if (tmo_q == '0) begin
          frame_err_q <= 1'b1;
          state_q     <= IDLE;
          tmo_q       <= TMO_LOAD;
        end else begin
          tmo_q <= tmo_q - 1'b1;
        end
      end else begin
        tmo_q <= TMO_LOAD;
      end
    end
  end

  // Decode of the byte delivered in the previous cycle
  logic                ext_pend_q, brk_pend_q, overflow_q;
  logic [NUM_KEYS-1:0] key_down_q, match_d;
  logic                is_e0_d, is_f0_d, is_drop_d, rep_d, push_d, pop_d, full_d;
  logic [10:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;

  always_comb begin
    is_e0_d   = (rx_byte_q == 8'hE0);
    is_f0_d   = (rx_byte_q == 8'hF0);
    is_drop_d = 1'b0;
    case (rx_byte_q)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_drop_d = 1'b1;
      default: ;
    endcase
    match_d = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      match_d[i] = (KEYMAP[9*i +: 9] == {ext_pend_q, rx_byte_q});
    rep_d  = ~brk_pend_q & |(match_d & key_down_q);
    push_d = rx_valid_q & ~is_e0_d & ~is_f0_d & ~is_drop_d;
    pop_d  = (level_q != '0) & evt_ready_i;
    full_d = (level_q == FULL_LVL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      key_down_q <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      overflow_q <= 1'b0;
      if (parity_err_q || frame_err_q) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
      if (rx_valid_q) begin
        if (is_e0_d) begin
          ext_pend_q <= 1'b1;
        end else if (is_f0_d) begin
          brk_pend_q <= 1'b1;
        end else begin
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
          // Key state follows the event even when the queue drops it.
          if (!is_drop_d) begin
            for (int i = 0; i < NUM_KEYS; i++)
              if (match_d[i]) key_down_q[i] <= ~brk_pend_q;
          end
        end
      end
      if (push_d && (!full_d || pop_d)) begin
        mem_q[wr_ptr_q] <= {rx_byte_q, ext_pend_q, brk_pend_q, rep_d};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_d) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_d && full_d && !pop_d) overflow_q <= 1'b1;
      if (push_d && !full_d && !pop_d) level_q <= level_q + 1'b1;
      else if (pop_d && !push_d)       level_q <= level_q - 1'b1;
    end
  end

  assign evt_valid_o     = (level_q != '0);
  assign {evt_code_o, evt_ext_o, evt_break_o, evt_repeat_o} = mem_q[rd_ptr_q];
  assign fifo_level_o    = level_q;
  assign key_down_o      = key_down_q;
  assign rx_byte_o       = rx_byte_q;
  assign rx_byte_valid_o = rx_valid_q;
  assign parity_err_o    = parity_err_q;
  assign frame_err_o     = frame_err_q;
  assign overflow_o      = overflow_q;
  assign bat_ok_o        = bat_ok_q;

endmodule

// File: tb/tb_ps2_key_scanner.sv
module tb_ps2_key_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_ext, evt_break, evt_repeat;
  logic [7:0] evt_code, rx_byte;
  logic [2:0] fifo_level;
  logic [3:0] key_down;
  logic       rx_byte_valid, parity_err, frame_err, overflow, bat_ok;

  ps2_key_scanner #(
    .FILTER_LEN(4), .TIMEOUT_CYC(2000), .FIFO_DEPTH(4), .NUM_KEYS(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_code_o(evt_code),
    .evt_ext_o(evt_ext), .evt_break_o(evt_break), .evt_repeat_o(evt_repeat),
    .fifo_level_o(fifo_level), .key_down_o(key_down), .rx_byte_o(rx_byte),
    .rx_byte_valid_o(rx_byte_valid), .parity_err_o(parity_err),
    .frame_err_o(frame_err), .overflow_o(overflow), .bat_ok_o(bat_ok)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int n_rxv = 0, n_perr = 0, n_ferr = 0, n_ovf = 0, n_bat = 0;
  int t_rxv = 0, t_evt = 0;
  logic evt_valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_byte_valid) begin n_rxv++; t_rxv = cyc; end
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
      if (overflow)   n_ovf++;
      if (bat_ok)     n_bat++;
      if (evt_valid && !evt_valid_prev) t_evt = cyc;
    end
    evt_valid_prev = evt_valid;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Sends the first nbits of a frame {stop, parity, data, start}, 40-cycle half period.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input int nbits);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (20) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (40) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_wait(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
    repeat (100) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         stop;
    bit         ev;
    logic [7:0] code;
    bit         ext, brk, rep;
    logic [3:0] kd;
    bit         perr, ferr, bat;
  } vec_t;

  vec_t tv[$];
  logic [7:0] exp_code[4];
  bit         exp_ext[4];

  initial begin
    int b_rxv, b_perr, b_ferr, b_ovf, b_bat, k;

    //           b     bp sp ev code  x  b  r  kd       pe fe bat
    tv.push_back('{8'h1D, 0, 1, 1, 8'h1D, 0, 0, 0, 4'b0001, 0, 0, 0});
    tv.push_back('{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0, 4'b0001, 0, 0, 0});
    tv.push_back('{8'h1D, 0, 1, 1, 8'h1D, 0, 1, 0, 4'b0000, 0, 0, 0});
    tv.push_back('{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 0});
    tv.push_back('{8'h75, 0, 1, 1, 8'h75, 1, 0, 0, 4'b0100, 0, 0, 0});
    tv.push_back('{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0, 4'b0100, 0, 0, 0});
    tv.push_back('{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0, 4'b0100, 0, 0, 0});
    tv.push_back('{8'h75, 0, 1, 1, 8'h75, 1, 1, 0, 4'b0000, 0, 0, 0});
    tv.push_back('{8'h1D, 0, 1, 1, 8'h1D, 0, 0, 0, 4'b0001, 0, 0, 0});
    tv.push_back('{8'h1D, 0, 1, 1, 8'h1D, 0, 0, 1, 4'b0001, 0, 0, 0});
    tv.push_back('{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0, 4'b0001, 0, 0, 0});
    tv.push_back('{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0, 4'b0001, 0, 0, 0});
    tv.push_back('{8'h1D, 1, 1, 0, 8'h00, 0, 0, 0, 4'b0001, 1, 0, 0});
    tv.push_back('{8'h1D, 0, 0, 0, 8'h00, 0, 0, 0, 4'b0001, 0, 1, 0});
    tv.push_back('{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0, 4'b0001, 0, 0, 0});
    tv.push_back('{8'h75, 1, 1, 0, 8'h00, 0, 0, 0, 4'b0001, 1, 0, 0});
    tv.push_back('{8'h75, 0, 1, 1, 8'h75, 0, 0, 0, 4'b0001, 0, 0, 0});
    tv.push_back('{8'hAA, 0, 1, 0, 8'h00, 0, 0, 0, 4'b0001, 0, 0, 1});
    tv.push_back('{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0, 4'b0001, 0, 0, 0});
    tv.push_back('{8'h1D, 0, 1, 1, 8'h1D, 0, 1, 0, 4'b0000, 0, 0, 0});

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_outputs", int'({evt_code, evt_ext, evt_break, evt_repeat, fifo_level, key_down,
                              rx_byte, rx_byte_valid, parity_err, frame_err, overflow, bat_ok}), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_pulses", n_rxv + n_perr + n_ferr + n_ovf + n_bat, 0);

    // Table-driven frames, one popped event per good non-prefix byte
    foreach (tv[i]) begin
      b_rxv = n_rxv; b_perr = n_perr; b_ferr = n_ferr; b_bat = n_bat;
      send_frame(tv[i].b, tv[i].bad_par, tv[i].stop, 11);
      repeat (100) @(negedge clk);
      chk($sformatf("v%0d_rxv", i), n_rxv - b_rxv, int'(!tv[i].bad_par && tv[i].stop));
      if (!tv[i].bad_par && tv[i].stop) chk($sformatf("v%0d_rx_byte", i), int'(rx_byte), int'(tv[i].b));
      chk($sformatf("v%0d_perr", i), n_perr - b_perr, int'(tv[i].perr));
      chk($sformatf("v%0d_ferr", i), n_ferr - b_ferr, int'(tv[i].ferr));
      chk($sformatf("v%0d_bat", i), n_bat - b_bat, int'(tv[i].bat));
      chk($sformatf("v%0d_key_down", i), int'(key_down), int'(tv[i].kd));
      chk($sformatf("v%0d_level", i), int'(fifo_level), int'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("v%0d_event", i), int'({evt_valid, evt_code, evt_ext, evt_break, evt_repeat}),
            int'({1'b1, tv[i].code, tv[i].ext, tv[i].brk, tv[i].rep}));
        if (i == 0) chk("evt_latency_after_rxv", t_evt - t_rxv, 1);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_popped", i), int'({evt_valid, fifo_level}), 0);
      end
    end

    // Glitch shorter than the filter
    b_rxv = n_rxv; b_perr = n_perr; b_ferr = n_ferr;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_no_activity", (n_rxv - b_rxv) + (n_perr - b_perr) + (n_ferr - b_ferr), 0);

    // Partial frame then timeout
    b_ferr = n_ferr; b_rxv = n_rxv;
    send_frame(8'h1D, 1'b0, 1'b1, 5);
    repeat (1800) @(negedge clk);
    chk("timeout_not_early", n_ferr - b_ferr, 0);
    for (int i = 0; i < 400 && n_ferr == b_ferr; i++) @(negedge clk);
    chk("timeout_ferr", n_ferr - b_ferr, 1);
    chk("timeout_no_byte", n_rxv - b_rxv, 0);
    send_wait(8'h1C);
    chk("after_timeout_event", int'({evt_valid, evt_code, evt_ext, evt_break, evt_repeat}),
        int'({1'b1, 8'h1C, 3'b000}));
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;

    // Overflow: four queued, two dropped, key map still follows the dropped make
    b_ovf = n_ovf;
    send_wait(8'h1C);
    send_wait(8'h1D);
    send_wait(8'h1B);
    send_wait(8'hE0); send_wait(8'h72);
    chk("ovf_none_yet", n_ovf - b_ovf, 0);
    send_wait(8'hE0); send_wait(8'h75);
    send_wait(8'h1C);
    chk("ovf_level", int'(fifo_level), 4);
    chk("ovf_pulses", n_ovf - b_ovf, 2);
    chk("ovf_key_down", int'(key_down), 4'b1111);
    exp_code = '{8'h1C, 8'h1D, 8'h1B, 8'h72};
    exp_ext  = '{1'b0, 1'b0, 1'b0, 1'b1};
    k = 0;
    @(negedge clk);
    evt_ready = 1'b1;
    for (int i = 0; i < 20 && k < 4; i++) begin
      if (evt_valid) begin
        chk($sformatf("drain%0d", k), int'({evt_code, evt_ext, evt_break, evt_repeat}),
            int'({exp_code[k], exp_ext[k], 2'b00}));
        k++;
      end
      @(negedge clk);
    end
    evt_ready = 1'b0;
    chk("drain_count", k, 4);
    chk("drain_empty", int'({evt_valid, fifo_level}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
